// File: rtl/s1_fetch_if.sv
// Stage-1 fetch bundle: next-PC control, BIOS/IMEM read ports and the stage-2 pipeline register.
// master = fetch stage, slave = surrounding core (control, memories, stage 2).
interface s1_fetch_if;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic        stall;

  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;

  logic [31:0] instruction_s2;
  logic [31:0] pc_s2;
  logic        valid_s2;

  modport master (
    input  pc_sel, branch_target, jal_target, stall, bios_dout, imem_dout,
    output bios_addr, imem_addr, instruction_s2, pc_s2, valid_s2
  );

  modport slave (
    output pc_sel, branch_target, jal_target, stall, bios_dout, imem_dout,
    input  bios_addr, imem_addr, instruction_s2, pc_s2, valid_s2
  );
endinterface

// File: rtl/s1_fetch.sv
// RV32I stage 1: owns the fetch PC, drives synchronous BIOS/IMEM reads and registers the fetched
// instruction into stage 2, squashing to a NOP bubble on redirect, boot and unmapped fetches.
module s1_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  s1_fetch_if.master bus
);

  typedef enum logic [1:0] {
    SrcBios     = 2'd0,
    SrcImem     = 2'd1,
    SrcUnmapped = 2'd2
  } src_e;

  logic [31:0] pc_f_q;
  src_e        src_f_q;
  logic        boot_q;
  logic [31:0] instr_s2_q;
  logic [31:0] pc_s2_q;
  logic        valid_s2_q;

  logic [31:0] next_pc;
  logic [31:0] fetched;
  logic        redirect;

  function automatic src_e decode_region(input logic [31:0] pc);
    case (pc[31:28])
      4'h4:    decode_region = SrcBios;
      4'h1:    decode_region = SrcImem;
      default: decode_region = SrcUnmapped;
    endcase
  endfunction

  assign redirect = (bus.pc_sel != 2'd0);

  // Redirects outrank stall; a stall re-reads pc_f so its data reappears next cycle.
  always_comb begin
    next_pc = pc_f_q + 32'd4;
    if (bus.pc_sel == 2'd3) begin
      next_pc = RESET_PC;
    end else if (bus.pc_sel == 2'd2) begin
      next_pc = bus.jal_target;
    end else if (bus.pc_sel == 2'd1) begin
      next_pc = bus.branch_target;
    end else if (bus.stall) begin
      next_pc = pc_f_q;
    end
  end

  assign bus.bios_addr = next_pc[13:2];
  assign bus.imem_addr = next_pc[15:2];

  always_comb begin
    fetched = NOP_INSTR;
    case (src_f_q)
      SrcBios: fetched = bus.bios_dout;
      SrcImem: fetched = bus.imem_dout;
      default: fetched = NOP_INSTR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f_q     <= RESET_PC - 32'd4;
      src_f_q    <= SrcUnmapped;
      boot_q     <= 1'b1;
      instr_s2_q <= NOP_INSTR;
      pc_s2_q    <= RESET_PC - 32'd4;
      valid_s2_q <= 1'b0;
    end else begin
      pc_f_q  <= next_pc;
      src_f_q <= decode_region(next_pc);
      boot_q  <= 1'b0;
      if (redirect) begin
        // Data on the memory outputs this cycle is wrong-path.
        instr_s2_q <= NOP_INSTR;
        valid_s2_q <= 1'b0;
        pc_s2_q    <= pc_f_q;
      end else if (bus.stall) begin
        instr_s2_q <= instr_s2_q;
        valid_s2_q <= valid_s2_q;
        pc_s2_q    <= pc_s2_q;
      end else if (boot_q || (src_f_q == SrcUnmapped)) begin
        instr_s2_q <= NOP_INSTR;
        valid_s2_q <= 1'b0;
        pc_s2_q    <= pc_f_q;
      end else begin
        instr_s2_q <= fetched;
        valid_s2_q <= 1'b1;
        pc_s2_q    <= pc_f_q;
      end
    end
  end

  assign bus.instruction_s2 = instr_s2_q;
  assign bus.pc_s2          = pc_s2_q;
  assign bus.valid_s2       = valid_s2_q;

endmodule

// File: doc/s1_fetch.md
Name: s1_fetch

Overview:
First pipeline stage of the 3-stage RV32I core. Owns the fetch PC and drives the BIOS and IMEM synchronous-read ports. Resolves next-PC from the pc_sel code produced by stage-3 control. Registers instruction/PC/valid into stage 2 and inserts a NOP bubble on every redirect, at boot, and on unmapped fetches.

Parameters:
RESET_PC, 32'h4000_0000, PC loaded on reset and on pc_sel==3 (BIOS base)
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
pc_sel  in  2  next-PC select: 0 seq, 1 branch/jalr target, 2 jal target, 3 RESET_PC
branch_target  in  32  target from stage-2 ALU (pc_sel==1)
jal_target  in  32  jal target (pc_sel==2)
stall  in  1  hazard hold from stage 2
bios_addr  out  12  BIOS word address, = next_pc[13:2]
bios_dout  in  32  BIOS read data, valid 1 cycle after bios_addr
imem_addr  out  14  IMEM word address, = next_pc[15:2]
imem_dout  in  32  IMEM read data, valid 1 cycle after imem_addr
instruction_s2  out  32  registered instruction to stage 2
pc_s2  out  32  registered PC of instruction_s2
valid_s2  out  1  1 = instruction_s2 is real, 0 = bubble

Behaviour:
- State regs: pc_f (PC whose data is on the memory outputs this cycle); src_f (2 bits: BIOS / IMEM / unmapped for pc_f); boot (1 for the first cycle after reset); output regs instruction_s2, pc_s2, valid_s2.
- Reset (rst==0, async): pc_f=RESET_PC-4; src_f=unmapped; boot=1; instruction_s2=NOP_INSTR; pc_s2=RESET_PC-4; valid_s2=0.
- next_pc (combinational), priority top-down:
  - pc_sel==3: RESET_PC
  - pc_sel==2: jal_target
  - pc_sel==1: branch_target
  - stall: pc_f
  - else: pc_f+4
  - Adds are mod 2^32; no alignment check (bits[1:0] ignored for addressing).
- Address outputs are driven from next_pc every cycle (memories read each cycle). A stall re-reads pc_f, so held data reappears next cycle. No skid buffer.
- Region decode on next_pc[31:28], registered into src_f at the edge: 4'h4 = BIOS, 4'h1 = IMEM, anything else = unmapped. pc_f<=next_pc every edge.
- fetched word = bios_dout if src_f==BIOS, imem_dout if IMEM, NOP_INSTR if unmapped.
- Output register update, each edge, priority top-down:
  - pc_sel!=0 (redirect; current fetch is wrong-path): instruction_s2=NOP_INSTR, valid_s2=0, pc_s2=pc_f.
  - stall: hold all three outputs.
  - boot==1 or src_f==unmapped: instruction_s2=NOP_INSTR, valid_s2=0, pc_s2=pc_f.
  - else: instruction_s2=fetched word, pc_s2=pc_f, valid_s2=1.
- boot clears at the first edge after reset release.
- Redirect overrides stall. Exactly one bubble per redirect; the target instruction reaches stage 2 two edges after the redirect cycle.
- Back-to-back redirects each squash; the last one wins.
- Reset asserted mid-operation: immediate async return to the reset values; any in-flight fetch is discarded.
- Latency: address issued at edge n; instruction_s2 valid after edge n+1 absent stall or redirect.

Test Plan:
- Boot: release rst, pc_sel=0, no stall. Addresses first show 0x4000_0000 (bios_addr=0). valid_s2=0 for cycle 1. Then pc_s2=0x4000_0000, instruction_s2=bios word 0, valid_s2=1. Next pc_s2=0x4000_0004.
- Sequential IMEM: jal redirect to 0x1000_0000 (pc_sel=2). One bubble, valid_s2=0. Then pc_s2=0x1000_0000, 0x1000_0004, 0x1000_0008 with imem words 0,1,2 and imem_addr incrementing by 1.
- Branch taken with stall: pc_sel=1, branch_target=0x1000_0040, stall=1 in the same cycle. Redirect wins: bubble, then pc_s2=0x1000_0040, valid_s2=1.
- Stall hold: stall=1 for 3 cycles mid-stream at pc_s2=0x1000_0008. All three outputs held, imem_addr constant. On release, pc_s2=0x1000_000C next with correct data and no duplicate.
- Unmapped fetch: branch_target=0x2000_0000. Bubble for the redirect, then instruction_s2=0x0000_0013, valid_s2=0 each cycle while PC stays unmapped.
- Async reset mid-stream: drop rst between edges while pc_s2=0x1000_0010. Outputs immediately go NOP/valid 0. pc_sel=3 later reloads 0x4000_0000 with one bubble.
